// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, per-frame configuration and received-word
// outputs of the UART receiver. The master side drives the line and the
// configuration; the slave side (the receiver) returns data and strobes.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            prescale;
  logic                  parity_enable;
  logic                  parity_type;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;

  modport master (
    output RX_IN, prescale, parity_enable, parity_type,
    input  P_DATA, data_valid, parity_error, stop_error
  );

  modport slave (
    input  RX_IN, prescale, parity_enable, parity_type,
    output P_DATA, data_valid, parity_error, stop_error
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, DATA_WIDTH data bits LSB-first,
// optional even/odd parity, one stop bit). Each bit is decided at mid-bit;
// prescale and parity settings are latched on the start edge.
// Optional feature macro: UART_RX_MAJORITY_EN -- when defined, every bit is
// the majority of the samples at mid-1, mid and mid+1, decided at mid+1.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input logic     CLK,
  input logic     RST,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CHECK} state_t;

  localparam int             BCW     = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_WIDTH);
  localparam logic [BCW-1:0] BC_ONE  = BCW'(1);

  state_t                state_q;
  logic [5:0]            edge_cnt_q;
  logic [5:0]            ps_q;
  logic                  par_en_q;
  logic                  par_type_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  par_flag_q;
  logic                  dv_q;
  logic                  pe_q;
  logic                  se_q;
`ifdef UART_RX_MAJORITY_EN
  logic                  samp0_q;
  logic                  samp1_q;
`endif

  logic [5:0] mid_d;
  logic [5:0] dec_pt_d;
  logic [5:0] edge_nxt_d;
  logic       decide_d;
  logic       bit_end_d;
  logic       bit_d;
  logic       exp_par_d;

  // Decision point, bit value and end-of-bit detection for the current frame
  always_comb begin
    mid_d = {1'b0, ps_q[5:1]};
`ifdef UART_RX_MAJORITY_EN
    dec_pt_d = mid_d + 6'd1;
    bit_d    = (samp0_q & samp1_q) | (samp0_q & bus.RX_IN) | (samp1_q & bus.RX_IN);
`else
    dec_pt_d = mid_d;
    bit_d    = bus.RX_IN;
`endif
    decide_d   = (edge_cnt_q == dec_pt_d);
    bit_end_d  = (edge_cnt_q == ps_q - 6'd1);
    edge_nxt_d = bit_end_d ? 6'd0 : edge_cnt_q + 6'd1;
    exp_par_d  = (^shift_q) ^ par_type_q;
  end

  // Receive FSM with registered data and one-cycle outcome strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      ps_q       <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      par_flag_q <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      samp0_q    <= 1'b0;
      samp1_q    <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      // Early samples for the vote; the third one is taken live at mid+1
      if (edge_cnt_q == mid_d - 6'd1) samp0_q <= bus.RX_IN;
      if (edge_cnt_q == mid_d)        samp1_q <= bus.RX_IN;
`endif
      case (state_q)
        IDLE: begin
          edge_cnt_q <= '0;
          if (!bus.RX_IN) begin
            // This cycle is edge 0 of the start bit
            state_q    <= START;
            edge_cnt_q <= 6'd1;
            ps_q       <= bus.prescale;
            par_en_q   <= bus.parity_enable;
            par_type_q <= bus.parity_type;
            bit_cnt_q  <= '0;
            par_flag_q <= 1'b0;
          end
        end
        START: begin
          edge_cnt_q <= edge_nxt_d;
          if (decide_d && bit_d) begin
            // Line back high at mid-bit: a glitch, not a start bit
            state_q    <= IDLE;
            edge_cnt_q <= '0;
          end else if (bit_end_d) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          edge_cnt_q <= edge_nxt_d;
          if (decide_d) begin
            shift_q   <= {bit_d, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_q <= bit_cnt_q + BC_ONE;
          end
          if (bit_end_d && (bit_cnt_q == BC_LAST)) begin
            state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          edge_cnt_q <= edge_nxt_d;
          if (decide_d) par_flag_q <= (bit_d != exp_par_d);
          if (bit_end_d) state_q <= STOP;
        end
        STOP: begin
          edge_cnt_q <= edge_nxt_d;
          if (decide_d) begin
            // Outcome registered here so it is visible during CHECK
            state_q    <= CHECK;
            edge_cnt_q <= '0;
            se_q       <= ~bit_d;
            pe_q       <= par_flag_q;
            if (bit_d && !par_flag_q) begin
              dv_q     <= 1'b1;
              p_data_q <= shift_q;
            end
          end
        end
        CHECK: begin
          state_q    <= IDLE;
          edge_cnt_q <= '0;
        end
        default: begin
          state_q    <= IDLE;
          edge_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.P_DATA       = p_data_q;
  assign bus.data_valid   = dv_q;
  assign bus.parity_error = pe_q;
  assign bus.stop_error   = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with hand-computed outcomes; a scoreboard
// queue holds the expected strobe (kind, P_DATA, absolute cycle) and a
// negedge monitor pops and compares whenever any strobe is seen.
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
    longint     cyc;
  } exp_t;

  logic   CLK;
  logic   RST;
  longint cyc;
  int     tests;
  int     fails;
  exp_t   exp_q[$];
  exp_t   mon_e;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: any strobe must match the oldest queued expectation
  always @(negedge CLK) begin
    if (bus.data_valid === 1'b1 || bus.parity_error === 1'b1 || bus.stop_error === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: dv=%b pe=%b se=%b P_DATA=%h, expected no strobe (cycle %0d)",
                 bus.data_valid, bus.parity_error, bus.stop_error, bus.P_DATA, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_cycle", cyc, mon_e.cyc);
        chk("data_valid", longint'(bus.data_valid), longint'(mon_e.dv));
        chk("parity_error", longint'(bus.parity_error), longint'(mon_e.pe));
        chk("stop_error", longint'(bus.stop_error), longint'(mon_e.se));
        chk("P_DATA", longint'(bus.P_DATA), longint'(mon_e.data));
      end
    end
  end

  // Drive one frame; called and returns at #1 after a rising edge
  task automatic send_frame(input logic [7:0] d, input logic [5:0] ps, input logic pen,
                            input logic pt, input logic pbit, input logic sbit,
                            input int glitch_t, input bit push,
                            input logic edv, input logic epe, input logic ese,
                            input logic [7:0] edata, input int lat);
    logic [10:0] bits;
    int          nb;
    exp_t        e;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (pen) begin
      bits[9]  = pbit;
      bits[10] = sbit;
      nb       = 11;
    end else begin
      bits[9]  = sbit;
      nb       = 10;
    end
    bus.prescale      = ps;
    bus.parity_enable = pen;
    bus.parity_type   = pt;
    if (push) begin
      e.dv   = edv;
      e.pe   = epe;
      e.se   = ese;
      e.data = edata;
      e.cyc  = cyc + longint'(lat);
      exp_q.push_back(e);
    end
    for (int t = 0; t < nb * int'(ps); t++) begin
      bus.RX_IN = bits[t / int'(ps)] ^ (t == glitch_t);
      @(posedge CLK); #1;
    end
    bus.RX_IN = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    bus.RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests             = 0;
    fails             = 0;
    RST               = 1'b1;
    bus.RX_IN         = 1'b1;
    bus.prescale      = 6'd8;
    bus.parity_enable = 1'b0;
    bus.parity_type   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset held with the line toggling: all outputs stay 0
    for (int i = 0; i < 10; i++) begin
      bus.RX_IN = 1'(i & 1);
      @(negedge CLK);
      chk("reset_outputs", longint'({bus.data_valid, bus.parity_error, bus.stop_error, bus.P_DATA}), 0);
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    idle_cycles(4);

    // First frame after reset: 0x12, ps 8, no parity, S=9 -> 72+4+1
    send_frame(8'h12, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1,
               1'b1, 1'b0, 1'b0, 8'h12, 77 + MAJ);
    idle_cycles(5);

    // 0xA5, ps 8, even parity bit 0 -> data_valid at frame cycle 85
    send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1,
               1'b1, 1'b0, 1'b0, 8'hA5, 85 + MAJ);
    idle_cycles(5);

    // 0x3C, ps 16, odd parity, wrong bit 0 (correct is 1): 160+8+1
    send_frame(8'h3C, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1,
               1'b0, 1'b1, 1'b0, 8'hA5, 169 + MAJ);
    idle_cycles(5);

    // 0x81, ps 32, no parity, stop driven 0: 288+16+1
    send_frame(8'h81, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1,
               1'b0, 1'b0, 1'b1, 8'hA5, 305 + MAJ);
    // 0x5A right after; the receiver rearms on the still-low stop bit,
    // 14 (13 with vote) cycles ahead of this frame's start
    send_frame(8'h5A, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1,
               1'b1, 1'b0, 1'b0, 8'h5A, 291 + 2 * MAJ);
    idle_cycles(5);

    // 3-cycle low pulse at ps 8: start glitch, no strobe
    bus.prescale = 6'd8;
    bus.RX_IN    = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    idle_cycles(30);

    // Back-to-back frames at ps 16, no parity: 144+8+1
    send_frame(8'h00, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1,
               1'b1, 1'b0, 1'b0, 8'h00, 153 + MAJ);
    send_frame(8'hFF, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1,
               1'b1, 1'b0, 1'b0, 8'hFF, 153 + MAJ);
    idle_cycles(5);

    // 0x01, ps 8, even parity sent 0 (needs 1) and stop 0: both errors
    send_frame(8'h01, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b1,
               1'b0, 1'b1, 1'b1, 8'hFF, 85 + MAJ);
    idle_cycles(30);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inversion at mid of data bit 3 (frame cycle 4*8+4)
    send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 36, 1'b1,
               1'b1, 1'b0, 1'b0, 8'hA5, 78);
    idle_cycles(5);
`endif

    // Reset mid-frame: frame abandoned, no strobe, P_DATA cleared
    bus.prescale      = 6'd8;
    bus.parity_enable = 1'b0;
    bus.RX_IN         = 1'b0;
    repeat (30) begin
      @(posedge CLK); #1;
    end
    RST       = 1'b1;
    bus.RX_IN = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    idle_cycles(3);
    @(negedge CLK);
    chk("midreset_outputs", longint'({bus.data_valid, bus.parity_error, bus.stop_error, bus.P_DATA}), 0);
    @(posedge CLK); #1;

    // Receiver usable after the mid-frame reset
    send_frame(8'hC3, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1,
               1'b1, 1'b0, 1'b0, 8'hC3, 77 + MAJ);
    idle_cycles(10);

    // Every expected strobe must have been seen
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge CLK); #1;
    end
    chk("queue_drained", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
